serial_add_ctrl: RTL and testbench

- Bit-serial addition controller. One internal 1-bit full-adder cell plus a carry flip-flop performs a WIDTH-bit add over WIDTH clock cycles.
- Sits between a word-level requester (AES key-schedule / round-counter arithmetic) and the shared adder cell.
- Handles operand capture, LSB-first sequencing, carry chaining, result assembly and the valid/ready handshakes on both sides.

---
 rtl/serial_add_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_serial_add_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
//
// Bit-serial addition controller. One 1-bit full-adder cell and a carry
// flip-flop compute {cout, sum} = a + b + cin over WIDTH clock cycles,
// processing the operands LSB first.
//
// Handshakes:
//   - Input side : in_valid / in_ready. An operation is accepted on the edge
//                  where both are high. in_ready is high only while idle.
//   - Output side: out_valid / out_ready. The result is held stable until
//                  the consumer takes it.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   operands and cin present
//   in_ready   controller can accept an operation
//   a, b       WIDTH-bit operands
//   cin        carry-in for bit 0
//   sub        (SERIAL_ADD_SUB_EN only) 1 = compute a - b instead of a + b
//   out_valid  sum/cout valid
//   out_ready  consumer takes the result
//   sum        WIDTH-bit result
//   cout       carry out of bit WIDTH-1 (for subtraction: 1 = no borrow)
//   busy       high while an operation is in flight or awaiting hand-off
//
// Configuration:
//   SERIAL_ADD_SUB_EN  when defined, adds the sub port and the b-path
//                      inverter so the same cell can subtract.
// -----------------------------------------------------------------------------
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] counter;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
  logic [WIDTH-1:0] sum_sh_nxt;
  logic             carry_q;
  logic             carry_init;
  logic             last_bit;
  logic             accept;

  // Full-adder cell signals
  logic             cell_a, cell_b, cell_s, cell_co;

`ifdef SERIAL_ADD_SUB_EN
  logic             sub_q;

  // Subtraction is a + ~b + 1: invert b per bit and seed the carry with 1.
  assign cell_b     = b_sh[0] ^ sub_q;
  assign carry_init = sub ? 1'b1 : cin;
`else
  assign cell_b     = b_sh[0];
  assign carry_init = cin;
`endif

  assign cell_a  = a_sh[0];
  assign cell_s  = cell_a ^ cell_b ^ carry_q;
  assign cell_co = (cell_a & cell_b) | (carry_q & (cell_a ^ cell_b));

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at sum[0].
  assign sum_sh_nxt = WIDTH'({cell_s, sum_sh} >> 1);

  assign last_bit = (counter == CNT_W'(WIDTH - 1));

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  // NOTE: every clocked process uses non-blocking (<=) assignments so all
  // registers update from the same pre-edge values; blocking here would make
  // results depend on statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state and handshake outputs
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        accept   = in_valid;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        // in_valid is not looked at here: a new operation waits for IDLE.
        if (out_ready) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: operand capture, bit-serial shift, result load
  // ---------------------------------------------------------------------------
  // NOTE: all datapath registers (shift registers included) are cleared by
  // reset, so an abort mid-operation leaves no stale partial result visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh    <= '0;
      b_sh    <= '0;
      sum_sh  <= '0;
      carry_q <= 1'b0;
      counter <= '0;
      sum     <= '0;
      cout    <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      if (accept) begin
        a_sh    <= a;
        b_sh    <= b;
        carry_q <= carry_init;
        counter <= '0;
        sum_sh  <= '0;
`ifdef SERIAL_ADD_SUB_EN
        sub_q   <= sub;
`endif
      end else if (state == RUN) begin
        a_sh    <= a_sh >> 1;
        b_sh    <= b_sh >> 1;
        sum_sh  <= sum_sh_nxt;
        carry_q <= cell_co;
        counter <= counter + CNT_W'(1);
        // Publish the result on the final bit; sum/cout then hold until the
        // next operation completes.
        if (last_bit) begin
          sum  <= sum_sh_nxt;
          cout <= cell_co;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_add_ctrl
//
// Self-checking bench for serial_add_ctrl (WIDTH = 8). Directed cases plus
// randomized operations, each compared against an arithmetic reference
// (a + b + cin, or a - b with the borrow flag when SERIAL_ADD_SUB_EN is set).
// -----------------------------------------------------------------------------
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         cin;
`ifdef SERIAL_ADD_SUB_EN
  logic         sub;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One complete operation. Inputs change and outputs are sampled 1 time
  // unit after each rising edge. hold = cycles out_ready stays low once the
  // result is up; jam = keep in_valid high and scramble the operand inputs
  // while the operation is in flight and through the hand-off edge.
  task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                        input logic op_cin, input logic op_sub,
                        input int hold, input bit jam);
    logic [W:0]   full;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    int           lat;

    if (op_sub) begin
      exp_sum  = op_a - op_b;
      exp_cout = (op_a >= op_b);
    end else begin
      full     = {1'b0, op_a} + {1'b0, op_b} + {{W{1'b0}}, op_cin};
      exp_sum  = full[W-1:0];
      exp_cout = full[W];
    end

    check("idle_in_ready", in_ready, 1);
    a         = op_a;
    b         = op_b;
    cin       = op_cin;
`ifdef SERIAL_ADD_SUB_EN
    sub       = op_sub;
`endif
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    if (!jam) in_valid = 1'b0;

    lat = 0;
    while (!out_valid && lat < W + 4) begin
      check("run_in_ready", in_ready, 0);
      check("run_busy", busy, 1);
      if (jam) begin
        a   = W'($urandom);
        b   = W'($urandom);
        cin = 1'($urandom);
`ifdef SERIAL_ADD_SUB_EN
        sub = 1'($urandom);
`endif
      end
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, W);
    check("sum", sum, exp_sum);
    check("cout", cout, exp_cout);
    check("done_in_ready", in_ready, 0);

    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_out_valid", out_valid, 1);
      check("hold_sum", sum, exp_sum);
      check("hold_cout", cout, exp_cout);
      check("hold_in_ready", in_ready, 0);
    end

    out_ready = 1'b1;
    @(posedge clk); #1;
    check("handoff_out_valid", out_valid, 0);
    check("handoff_busy", busy, 0);
    check("handoff_in_ready", in_ready, 1);
    check("handoff_sum_kept", sum, exp_sum);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    // One idle edge confirms no second result appears for this accept.
    @(posedge clk); #1;
    check("post_out_valid", out_valid, 0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    sub       = 1'b0;
`endif

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);

    // Directed cases
    run_op(8'h5A, 8'h3C, 1'b0, 1'b0, 0, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 0, 1'b0);
    run_op(8'hFF, 8'h00, 1'b1, 1'b0, 0, 1'b0);
    run_op(8'h12, 8'h34, 1'b0, 1'b0, 5, 1'b0);

    // Abort mid-operation: accept, three RUN edges, then assert reset.
    @(posedge clk); #1;
    a        = 8'hAA;
    b        = 8'h55;
    cin      = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_busy_before", busy, 1);
    rst = 1'b1;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_sum", sum, 0);
    check("abort_cout", cout, 0);
    check("abort_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < W + 2; i++) begin
      @(posedge clk); #1;
      check("abort_no_valid", out_valid, 0);
    end
    run_op(8'h01, 8'h01, 1'b0, 1'b0, 0, 1'b0);

    // Inputs toggling while busy, with in_valid high through the hand-off.
    run_op(8'hA5, 8'h5A, 1'b1, 1'b0, 2, 1'b1);

`ifdef SERIAL_ADD_SUB_EN
    run_op(8'h10, 8'h01, 1'b0, 1'b1, 0, 1'b0);
    run_op(8'h00, 8'h01, 1'b1, 1'b1, 1, 1'b0);
`endif

    // Randomized operations
    for (int n = 0; n < 30; n++) begin
      logic op_sub;
      op_sub = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
      op_sub = 1'($urandom);
`endif
      run_op(W'($urandom), W'($urandom), 1'($urandom), op_sub,
             int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
